// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache line-port arbiter: FSM states, owner encoding
// and default bus widths.
package arbiter_types;

    localparam int DEFAULT_LINE_W = 256;
    localparam int DEFAULT_ADDR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_I    = 3'd1,
        ST_SERVE_D_RD = 3'd2,
        ST_SERVE_D_WR = 3'd3,
        ST_DONE_I     = 3'd4,
        ST_DONE_D     = 3'd5
    } arb_state_t;

    // Encoding doubles as the grant output
    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_I    = 2'b01,
        OWNER_D    = 2'b10
    } owner_t;

endpackage

// File: rtl/cache_arbiter_rr_pick2.sv
// Two-requester alternating-priority picker; purely combinational.
// On a tie the requester that did not own the port last wins.
module rr_pick2
    import arbiter_types::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_owner,
    output owner_t owner
);

    always_comb begin
        owner = OWNER_NONE;
        if (req_i && req_d) begin
            owner = (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
        end else if (req_i) begin
            owner = OWNER_I;
        end else if (req_d) begin
            owner = OWNER_D;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Serialises I-cache refills and D-cache refill/writeback onto one memory line port.
// Request to pm strobe 1 cycle; resp one cycle after pm_resp; back to IDLE the cycle after.
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = DEFAULT_LINE_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pm_read,
    output logic              pm_write,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [LINE_W-1:0] pm_wdata,
    input  logic [LINE_W-1:0] pm_rdata,
    input  logic              pm_resp,
    output logic [1:0]        grant,
    output logic              proto_err
);

    arb_state_t        state_q, state_d;
    owner_t            last_owner_q;
    owner_t            pick;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic              proto_err_q;
    owner_t            grant_c;

    rr_pick2 u_pick (
        .req_i      (i_read),
        .req_d      (d_read | d_write),
        .last_owner (last_owner_q),
        .owner      (pick)
    );

    always_comb begin
        state_d  = state_q;
        pm_read  = 1'b0;
        pm_write = 1'b0;
        i_resp   = 1'b0;
        d_resp   = 1'b0;
        grant_c  = OWNER_NONE;
        case (state_q)
            ST_IDLE: begin
                if (pick == OWNER_I) begin
                    state_d = ST_SERVE_I;
                end else if (pick == OWNER_D) begin
                    // A dirty writeback must reach memory before the refill
                    state_d = d_write ? ST_SERVE_D_WR : ST_SERVE_D_RD;
                end
            end
            ST_SERVE_I: begin
                pm_read = 1'b1;
                grant_c = OWNER_I;
                if (pm_resp) state_d = ST_DONE_I;
            end
            ST_SERVE_D_RD: begin
                pm_read = 1'b1;
                grant_c = OWNER_D;
                if (pm_resp) state_d = ST_DONE_D;
            end
            ST_SERVE_D_WR: begin
                pm_write = 1'b1;
                grant_c  = OWNER_D;
                if (pm_resp) state_d = ST_DONE_D;
            end
            ST_DONE_I: begin
                i_resp  = 1'b1;
                grant_c = OWNER_I;
                state_d = ST_IDLE;
            end
            ST_DONE_D: begin
                d_resp  = 1'b1;
                grant_c = OWNER_D;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWNER_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                if (d_read && d_write) proto_err_q <= 1'b1;
                if (pick == OWNER_I) begin
                    addr_q       <= i_addr;
                    last_owner_q <= OWNER_I;
                end else if (pick == OWNER_D) begin
                    addr_q       <= d_addr;
                    last_owner_q <= OWNER_D;
                    if (d_write) wdata_q <= d_wdata;
                end
            end
            if (pm_resp && state_q == ST_SERVE_I)    i_rdata_q <= pm_rdata;
            if (pm_resp && state_q == ST_SERVE_D_RD) d_rdata_q <= pm_rdata;
        end
    end

    assign pm_addr   = addr_q;
    assign pm_wdata  = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign grant     = grant_c;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single-requester latency, writeback, ties,
// alternation, protocol error and mid-transaction reset.
module tb_cache_arbiter;
    import arbiter_types::*;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pm_read;
    logic          pm_write;
    logic [AW-1:0] pm_addr;
    logic [LW-1:0] pm_wdata;
    logic [LW-1:0] pm_rdata = '0;
    logic          pm_resp = 1'b0;
    logic [1:0]    grant;
    logic          proto_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pm_read(pm_read), .pm_write(pm_write), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .pm_rdata(pm_rdata), .pm_resp(pm_resp),
        .grant(grant), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read transaction with a 1-cycle memory; starts in IDLE with requests set.
    // keep re-raises the served requester in the IDLE cycle after its resp.
    task automatic do_txn(input logic [1:0] exp_owner, input logic [AW-1:0] exp_addr,
                          input logic [LW-1:0] data, input bit keep);
        int n = 0;
        while (grant == 2'b00 && n < 10) begin
            tick();
            n++;
        end
        chk("txn_wait", n, 1);
        chk("txn_grant", grant, exp_owner);
        chk("txn_pm_read", pm_read, 1'b1);
        chk("txn_pm_addr", pm_addr, exp_addr);
        pm_resp  = 1'b1;
        pm_rdata = data;
        tick();
        pm_resp = 1'b0;
        if (exp_owner == 2'b01) begin
            chk("txn_i_resp", i_resp, 1'b1);
            chk("txn_d_resp", d_resp, 1'b0);
            chk("txn_i_rdata", i_rdata, data);
            i_read = 1'b0;
        end else begin
            chk("txn_d_resp", d_resp, 1'b1);
            chk("txn_i_resp", i_resp, 1'b0);
            chk("txn_d_rdata", d_rdata, data);
            d_read = 1'b0;
        end
        tick();
        chk("txn_idle_grant", grant, 2'b00);
        if (keep) begin
            if (exp_owner == 2'b01) i_read = 1'b1;
            else d_read = 1'b1;
        end
    endtask

    initial begin
        logic [LW-1:0] pat_a;
        logic [LW-1:0] pat_5;
        logic [LW-1:0] pat_w;
        pat_a = {32{8'hAA}};
        pat_5 = {32{8'h55}};
        pat_w = {32{8'h3C}};

        // Reset state
        tick();
        chk("rst_pm_read", pm_read, 1'b0);
        chk("rst_pm_write", pm_write, 1'b0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_pm_addr", pm_addr, '0);
        rst = 1'b1;
        tick();

        // I-only read, 4-cycle memory
        i_read = 1'b1;
        i_addr = 32'h0000_1000;
        tick();
        for (int c = 1; c <= 4; c++) begin
            chk("i_pm_read", pm_read, 1'b1);
            chk("i_pm_write", pm_write, 1'b0);
            chk("i_pm_addr", pm_addr, 32'h0000_1000);
            chk("i_grant", grant, 2'b01);
            chk("i_early_resp", {i_resp, d_resp}, 2'b00);
            if (c == 2) i_addr = 32'h0000_DEAD;
            if (c == 4) begin
                pm_resp  = 1'b1;
                pm_rdata = pat_a;
            end
            tick();
        end
        pm_resp  = 1'b0;
        pm_rdata = '0;
        chk("i_resp_pulse", i_resp, 1'b1);
        chk("i_d_resp_quiet", d_resp, 1'b0);
        chk("i_rdata", i_rdata, pat_a);
        chk("i_pm_read_drop", pm_read, 1'b0);
        i_read = 1'b0;
        tick();
        chk("i_resp_single", i_resp, 1'b0);
        chk("i_rdata_held", i_rdata, pat_a);
        chk("i_idle_grant", grant, 2'b00);

        // Stray pm_resp in IDLE is ignored
        pm_resp  = 1'b1;
        pm_rdata = {32{8'hEE}};
        tick();
        pm_resp = 1'b0;
        chk("stray_grant", grant, 2'b00);
        chk("stray_resp", {i_resp, d_resp}, 2'b00);
        tick();
        chk("stray_i_rdata", i_rdata, pat_a);
        chk("stray_d_rdata", d_rdata, '0);

        // D writeback, 2-cycle memory
        d_write = 1'b1;
        d_addr  = 32'h0000_2020;
        d_wdata = pat_5;
        tick();
        for (int c = 1; c <= 2; c++) begin
            chk("dw_pm_write", pm_write, 1'b1);
            chk("dw_pm_read", pm_read, 1'b0);
            chk("dw_pm_wdata", pm_wdata, pat_5);
            chk("dw_pm_addr", pm_addr, 32'h0000_2020);
            chk("dw_grant", grant, 2'b10);
            if (c == 2) pm_resp = 1'b1;
            tick();
        end
        pm_resp = 1'b0;
        chk("dw_d_resp", d_resp, 1'b1);
        chk("dw_pm_write_drop", pm_write, 1'b0);
        chk("dw_pm_read_quiet", pm_read, 1'b0);
        chk("dw_proto_err", proto_err, 1'b0);
        d_write = 1'b0;
        tick();
        chk("dw_resp_single", d_resp, 1'b0);

        // Tie out of reset: I first, then D, then the next tie goes to I
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        i_read = 1'b1; i_addr = 32'h0000_0100;
        d_read = 1'b1; d_addr = 32'h0000_0200;
        do_txn(2'b01, 32'h0000_0100, {32{8'h11}}, 1'b0);
        do_txn(2'b10, 32'h0000_0200, {32{8'h22}}, 1'b0);
        i_read = 1'b1;
        d_read = 1'b1;
        do_txn(2'b01, 32'h0000_0100, {32{8'h33}}, 1'b1);

        // Held I plus continuous D misses: strict alternation
        do_txn(2'b10, 32'h0000_0200, {32{8'h44}}, 1'b1);
        do_txn(2'b01, 32'h0000_0100, {32{8'h66}}, 1'b1);
        do_txn(2'b10, 32'h0000_0200, {32{8'h77}}, 1'b1);
        do_txn(2'b01, 32'h0000_0100, {32{8'h88}}, 1'b0);
        d_read = 1'b0;
        tick();

        // d_read and d_write together: write wins, proto_err sticks
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h0000_0040;
        d_wdata = pat_w;
        tick();
        chk("pe_pm_write", pm_write, 1'b1);
        chk("pe_pm_read", pm_read, 1'b0);
        chk("pe_pm_addr", pm_addr, 32'h0000_0040);
        chk("pe_pm_wdata", pm_wdata, pat_w);
        chk("pe_proto_err", proto_err, 1'b1);
        pm_resp = 1'b1;
        tick();
        pm_resp = 1'b0;
        chk("pe_d_resp", d_resp, 1'b1);
        d_read  = 1'b0;
        d_write = 1'b0;
        tick();
        tick();
        chk("pe_proto_err_sticky", proto_err, 1'b1);

        // Reset mid-transaction in SERVE_I
        i_read = 1'b1;
        i_addr = 32'h0000_0500;
        tick();
        chk("mr_pm_read_before", pm_read, 1'b1);
        rst = 1'b0;
        #1;
        chk("mr_pm_read", pm_read, 1'b0);
        chk("mr_grant", grant, 2'b00);
        chk("mr_i_resp", i_resp, 1'b0);
        chk("mr_proto_err", proto_err, 1'b0);
        i_read = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mr_no_resp", {i_resp, d_resp}, 2'b00);
        end
        rst = 1'b1;
        tick();
        d_read = 1'b1;
        d_addr = 32'h0000_0080;
        do_txn(2'b10, 32'h0000_0080, {32{8'hCC}}, 1'b0);
        chk("mr_i_no_resp", i_resp, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined rv32i core.
- Sits between the two caches and the cacheline adaptor.
- Serialises one line transaction at a time.
- Resolves simultaneous requests with alternating priority, so neither fetch nor load/store misses starve while the hazard unit stalls the pipeline on imem_resp/dmem_resp.

Parameters:
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, line address width (low 5 bits are zero at the caches)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- pm_read  out  1  memory read strobe, held until pm_resp
- pm_write  out  1  memory write strobe, held until pm_resp
- pm_addr  out  ADDR_W  memory line address
- pm_wdata  out  LINE_W  memory write line
- pm_rdata  in  LINE_W  memory read line, valid with pm_resp
- pm_resp  in  1  memory completion
- grant  out  2  current owner: 00 none, 01 I, 10 D
- proto_err  out  1  sticky; set when d_read and d_write are both high in IDLE

Behaviour:
- Reset values (async on rst low): state IDLE; all outputs 0; last_owner = D, so I wins the first tie; latched address/data 0; proto_err 0.
- States: IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR, DONE_I, DONE_D.
- IDLE selection:
  - Only I requesting → SERVE_I.
  - Only D requesting → SERVE_D_RD or SERVE_D_WR.
  - Both requesting → the one not equal to last_owner.
  - No request → stay in IDLE.
- On leaving IDLE: latch address (and d_wdata for writes) into internal registers; update last_owner.
- pm_* outputs are driven only from latched registers and state, never combinationally from requester inputs.
- SERVE_*:
  - Assert pm_read (SERVE_I, SERVE_D_RD) or pm_write (SERVE_D_WR) continuously; grant reflects the owner.
  - On pm_resp: capture pm_rdata into the owner's rdata register (reads only) and go to DONE_I or DONE_D.
  - pm_read/pm_write drop in the same edge.
- DONE_*:
  - Assert i_resp or d_resp for exactly one cycle; rdata is stable during that cycle and held afterwards until the next capture.
  - Next state is always IDLE. The requester deasserts in response, so IDLE never re-serves a stale request.
- Latency: request seen in IDLE at cycle 0 → pm strobe at cycle 1 → pm_resp at cycle k → resp at k+1 → IDLE at k+2. Minimum 3 cycles with a 1-cycle memory.
- Back-to-back: a request pending in IDLE at k+2 is granted that cycle. No idle bubble beyond DONE.
- d_read and d_write both high: write wins (dirty writeback precedes refill); proto_err sets and stays set until reset.
- Requester changes address mid-transaction: ignored (latched copy is used).
- pm_resp outside SERVE_*: ignored.
- rst low mid-transaction: the transaction is abandoned with no resp pulse; the memory side is reset by the same signal.
- Only one pm strobe is ever high; pm_read & pm_write never both 1.

Decomposition:
- Package arbiter_types:
  - arb_state_t enum (six states)
  - owner_t enum (NONE=2'b00, I=2'b01, D=2'b10), used for grant and last_owner
  - LINE_W/ADDR_W defaults
- Sub-module rr_pick2 (two-requester alternating-priority picker):
  - inputs: req_i, req_d, last_owner
  - output: owner_t
  - combinational, unit-testable in isolation
- FSM, latches and response registers stay in cache_arbiter.

Test Plan:
- I-only read, i_addr=0x0000_1000, memory returns 0xAA..AA after 4 cycles → pm_read high cycles 1-4, pm_addr=0x1000, i_resp single pulse at cycle 5 with i_rdata=0xAA..AA, d_resp never asserts.
- D writeback, d_addr=0x0000_2020, d_wdata=0x5555..55, 2-cycle memory → pm_write high cycles 1-2 with pm_wdata=0x5555..55, d_resp pulse at cycle 3, pm_read stays 0.
- i_read and d_read raised same cycle out of reset → I served first (grant=01); D granted the cycle after DONE_I→IDLE (grant=10); the next tie goes to the other requester.
- Continuous D misses plus a held I request → grants alternate I, D, I, D over 4 transactions; no requester waits more than one transaction.
- d_read=d_write=1 with d_addr=0x40 → write performed (pm_write=1, pm_read=0); proto_err=1 and stays 1 after the transaction.
- rst driven low while in SERVE_I with pm_read=1 → pm_read, grant and i_resp 0 immediately, no resp pulse; after release, a fresh d_read is served normally.
